clk_enable_synth: RTL and testbench

Multi-channel fractional clock-enable synthesiser: from one reference clock it generates NUM_CH independent single-cycle enable strobes whose average rate is inc/2^ACC_W of the clock, each with a programmable phase. It is the next generation of our fixed two-output PLL wrappers. Logic derives slower rates (SDRAM refresh tick, peripheral baud, sample strobes) as enables on the PLL output clock instead of instantiating further PLLs. A `locked` output tells downstream logic when the configuration has settled, mirroring the PLL lock contract.

---
 rtl/clk_enable_synth_pkg.sv | 15 +
 rtl/clk_enable_synth_ch.sv | 38 +++
 rtl/clk_enable_synth.sv | 109 ++++++++++
 tb/tb_clk_enable_synth.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_synth_pkg.sv
// Shared types and sizing helpers for the fractional clock-enable synthesiser.
package clk_enable_synth_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    SETTLE   = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  // Settle counter must hold values 0..lock_cycles.
  function automatic int unsigned settle_cnt_w(input int unsigned lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_enable_synth_ch.sv
// One enable channel: phase accumulator, rate register and registered carry strobe.
module clk_enable_synth_ch #(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             strobe
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // A load wins over the running add so the new phase is the first addend.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      inc    <= '0;
      strobe <= 1'b0;
    end else if (load) begin
      acc    <= load_phase;
      inc    <= load_inc;
      strobe <= 1'b0;
    end else if (run) begin
      acc    <= sum[ACC_W-1:0];
      strobe <= sum[ACC_W];
    end else begin
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_enable_synth.sv
// Multi-channel fractional clock-enable synthesiser with a lock indicator that
// tracks settling after reset or reconfiguration.
module clk_enable_synth
  import clk_enable_synth_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                                         refclk,
  input  logic                                         rst,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                             cfg_inc,
  input  logic [ACC_W-1:0]                             cfg_phase,
  input  logic [NUM_CH-1:0]                            ch_en,
  output logic [NUM_CH-1:0]                            outclk_en,
  output logic                                         locked
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = settle_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  lock_state_e      state;
  lock_state_e      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ready_next;
  logic             locked_next;
  logic             cfg_take;
  logic             ch_in_range;
  logic [NUM_CH-1:0] ch_load;

  assign cfg_take    = cfg_valid & cfg_ready;
  assign ch_in_range = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  // State register; cfg_ready and locked are registered copies of the next-state decode.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cfg_ready <= ready_next;
      locked    <= locked_next;
    end
  end

  // Next state and settle counter; any accepted write restarts settling.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RST_HOLD: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
      SETTLE: begin
        if (cfg_take) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = LOCKED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (cfg_take) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = RST_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ready_next  = 1'b0;
    locked_next = 1'b0;
    ready_next  = (state_next != RST_HOLD);
    locked_next = (state_next == LOCKED);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_load[c] = cfg_take & ch_in_range & (cfg_ch == CH_W'(c));

    clk_enable_synth_ch #(
      .ACC_W(ACC_W)
    ) u_ch (
      .clk       (refclk),
      .rst       (rst),
      .run       (ch_en[c]),
      .load      (ch_load[c]),
      .load_inc  (cfg_inc),
      .load_phase(cfg_phase),
      .strobe    (outclk_en[c])
    );
  end

endmodule

// File: tb/tb_clk_enable_synth.sv
// Self-checking bench for clk_enable_synth: directed scenarios plus random traffic
// against an unbounded-position reference model.
module tb_clk_enable_synth;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned ACC_W       = 16;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam int unsigned CH_W        = 2;

  logic              refclk    = 1'b0;
  logic              rst       = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch    = '0;
  logic [ACC_W-1:0]  cfg_inc   = '0;
  logic [ACC_W-1:0]  cfg_phase = '0;
  logic [NUM_CH-1:0] ch_en     = '0;
  logic [NUM_CH-1:0] outclk_en;
  logic              locked;

  int errors = 0;
  int checks = 0;

  always #5 refclk = ~refclk;

  clk_enable_synth #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .ch_en    (ch_en),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  // Reference model: each channel is an unbounded position that advances by inc;
  // a strobe marks every crossing of a 2^ACC_W boundary.
  longint            pos  [NUM_CH];
  longint            minc [NUM_CH];
  logic [NUM_CH-1:0] exp_en     = '0;
  logic              exp_ready  = 1'b0;
  logic              exp_locked = 1'b0;
  longint            edge_n     = 0;
  longint            lock_at    = 64'd1 << 40;

  always @(posedge refclk) begin : model
    longint np;
    bit     take;
    edge_n++;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pos[c]  = 0;
        minc[c] = 0;
      end
      exp_en    = '0;
      exp_ready = 1'b0;
      lock_at   = edge_n + 1 + LOCK_CYCLES;
    end else begin
      take = cfg_valid && exp_ready;
      for (int c = 0; c < NUM_CH; c++) begin
        if (take && int'(cfg_ch) == c) begin
          pos[c]    = longint'(cfg_phase);
          minc[c]   = longint'(cfg_inc);
          exp_en[c] = 1'b0;
        end else if (ch_en[c]) begin
          np        = pos[c] + minc[c];
          exp_en[c] = ((np >> ACC_W) != (pos[c] >> ACC_W));
          pos[c]    = np;
        end else begin
          exp_en[c] = 1'b0;
        end
      end
      if (take) lock_at = edge_n + LOCK_CYCLES;
      exp_ready = 1'b1;
    end
    exp_locked = (edge_n >= lock_at);
  end

  task automatic do_write(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] inc,
                          input logic [ACC_W-1:0] phase);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_phase = phase;
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; ch_en = '0;
    repeat (3) @(negedge refclk);
    checks++; if (outclk_en !== 3'b000) begin errors++; $display("FAIL reset outclk_en: got %b want 000", outclk_en); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset locked: got %b want 0", locked); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset cfg_ready: got %b want 0", cfg_ready); end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge refclk);
      checks++; if (locked !== 1'(k >= 17)) begin errors++; $display("FAIL reset lock timing R+%0d: got %b want %b", k, locked, k >= 17); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset cfg_ready R+%0d: got %b want 1", k, cfg_ready); end
    end
  endtask

  task automatic test_half_rate();
    ch_en = 3'b001;
    do_write(2'd0, 16'h8000, 16'h0000);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge refclk);
      checks++; if (outclk_en[0] !== 1'((k > 0) && (k % 2 == 0))) begin errors++; $display("FAIL half rate N+%0d: got %b want %b", k, outclk_en[0], (k > 0) && (k % 2 == 0)); end
      checks++; if (outclk_en !== exp_en) begin errors++; $display("FAIL half rate model N+%0d: got %b want %b", k, outclk_en, exp_en); end
    end
  endtask

  task automatic test_quarter_phase();
    ch_en = 3'b011;
    do_write(2'd1, 16'h4000, 16'hC000);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge refclk);
      checks++; if (outclk_en[1] !== 1'(k % 4 == 1)) begin errors++; $display("FAIL quarter ch1 N+%0d: got %b want %b", k, outclk_en[1], k % 4 == 1); end
      checks++; if (outclk_en[0] !== 1'(k % 2 == 1)) begin errors++; $display("FAIL quarter ch0 cadence N+%0d: got %b want %b", k, outclk_en[0], k % 2 == 1); end
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 40 && locked !== 1'b1; i++) @(negedge refclk);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock wait: got %b want 1", locked); end
    do_write(2'd2, 16'h1234, 16'h0000);
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge refclk);
      checks++; if (locked !== 1'(k >= 16)) begin errors++; $display("FAIL relock N+%0d: got %b want %b", k, locked, k >= 16); end
      checks++; if (outclk_en !== exp_en) begin errors++; $display("FAIL relock strobes N+%0d: got %b want %b", k, outclk_en, exp_en); end
    end
  endtask

  task automatic test_back_to_back();
    ch_en = 3'b111;
    cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cfg_ch    = 2'd2;
      cfg_inc   = 16'($urandom);
      cfg_phase = 16'($urandom);
      @(negedge refclk);
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b cfg_ready %0d: got %b want 1", i, cfg_ready); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL b2b locked %0d: got %b want 0", i, locked); end
    end
    cfg_valid = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge refclk);
      checks++; if (locked !== 1'(k >= 16)) begin errors++; $display("FAIL b2b relock N+%0d: got %b want %b", k, locked, k >= 16); end
      checks++; if (outclk_en !== exp_en) begin errors++; $display("FAIL b2b strobes N+%0d: got %b want %b", k, outclk_en, exp_en); end
    end
  endtask

  task automatic test_ch_en_gate();
    ch_en = 3'b111;
    do_write(2'd0, 16'h4000, 16'h0000);
    repeat (2) @(negedge refclk);
    ch_en[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge refclk);
      checks++; if (outclk_en[0] !== 1'b0) begin errors++; $display("FAIL gate off %0d: got %b want 0", k, outclk_en[0]); end
    end
    ch_en[0] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge refclk);
      checks++; if (outclk_en[0] !== 1'(j == 2 || j == 6)) begin errors++; $display("FAIL gate resume %0d: got %b want %b", j, outclk_en[0], j == 2 || j == 6); end
      checks++; if (outclk_en !== exp_en) begin errors++; $display("FAIL gate model %0d: got %b want %b", j, outclk_en, exp_en); end
    end
  endtask

  task automatic test_bad_channel();
    for (int i = 0; i < 40 && locked !== 1'b1; i++) @(negedge refclk);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL badch lock wait: got %b want 1", locked); end
    do_write(2'd3, 16'($urandom), 16'($urandom));
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge refclk);
      checks++; if (locked !== 1'(k >= 16)) begin errors++; $display("FAIL badch locked N+%0d: got %b want %b", k, locked, k >= 16); end
      checks++; if (outclk_en !== exp_en) begin errors++; $display("FAIL badch strobes N+%0d: got %b want %b", k, outclk_en, exp_en); end
    end
  endtask

  task automatic test_zero_inc();
    int cnt = 0;
    ch_en = 3'b111;
    do_write(2'd1, 16'h0000, 16'hFFFF);
    for (int k = 0; k < 1000; k++) begin
      @(negedge refclk);
      if (outclk_en[1] === 1'b1) cnt++;
    end
    checks++; if (cnt != 0) begin errors++; $display("FAIL zero inc strobes: got %0d want 0", cnt); end
  endtask

  task automatic test_long_rate();
    localparam int unsigned N_CYC = 24576;
    int     cnt = 0;
    longint want;
    ch_en = 3'b001;
    do_write(2'd0, 16'h5555, 16'h0000);
    for (int k = 0; k < N_CYC; k++) begin
      @(negedge refclk);
      if (outclk_en[0] === 1'b1) cnt++;
    end
    want = (longint'(N_CYC) * 64'h5555) >> ACC_W;
    checks++; if (longint'(cnt) != want) begin errors++; $display("FAIL long rate count: got %0d want %0d", cnt, want); end
  endtask

  task automatic test_rst_mid();
    ch_en = 3'b111;
    do_write(2'd0, 16'h8000, 16'h0000);
    repeat (3) @(negedge refclk);
    rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'hFFFF; cfg_phase = 16'h0000;
    @(negedge refclk);
    rst = 1'b0; cfg_valid = 1'b0;
    checks++; if (outclk_en !== 3'b000) begin errors++; $display("FAIL rst mid outclk_en: got %b want 000", outclk_en); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst mid locked: got %b want 0", locked); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst mid cfg_ready: got %b want 0", cfg_ready); end
    @(negedge refclk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst mid ready return: got %b want 1", cfg_ready); end
    for (int k = 0; k < 50; k++) begin
      @(negedge refclk);
      checks++; if (outclk_en !== 3'b000) begin errors++; $display("FAIL rst mid inc cleared %0d: got %b want 000", k, outclk_en); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge refclk);
      checks++; if (outclk_en !== exp_en) begin errors++; $display("FAIL random strobes %0d: got %b want %b", k, outclk_en, exp_en); end
      checks++; if (locked !== exp_locked) begin errors++; $display("FAIL random locked %0d: got %b want %b", k, locked, exp_locked); end
      checks++; if (cfg_ready !== exp_ready) begin errors++; $display("FAIL random cfg_ready %0d: got %b want %b", k, cfg_ready, exp_ready); end
      rst       = ($urandom_range(0, 499) == 0);
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_inc   = 16'($urandom);
      cfg_phase = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ch_en = 3'($urandom);
    end
    rst = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_half_rate();
    test_quarter_phase();
    test_lock();
    test_back_to_back();
    test_ch_en_gate();
    test_bad_channel();
    test_zero_inc();
    test_long_rate();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
